pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined barrel shifter for WIDTH-bit operands.
- Supports logical/arithmetic shifts and rotates in both directions.
- One pipeline stage per shift-amount bit (shift by 2^k); valid/ready handshake on both sides.
- Used as the shift unit feeding the lab ALU/datapath; generalises the fixed 8-bit single-distance shift stages.

Parameters:
- WIDTH, 8, operand width in bits; must be a power of 2, >= 4
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden
- STAGES, SHW, pipeline depth; derived, equals SHW

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  shifter can accept input this cycle
- in_data  in  WIDTH  operand
- in_amt  in  SHW  shift amount, 0..WIDTH-1
- in_op  in  3  operation code (see Behaviour)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  shifted result

Behaviour:
- Reset: clk and rst_n only; reset is synchronous and active-low, sampled on the rising edge of clk.
  - While rst_n=0, all stage valid bits clear.
  - out_valid=0, out_data=0 (and out_carry=0 when the optional feature is enabled).
  - in_ready=1 from the first cycle after reset deassertion.
- Op codes: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR.
  - 101..111 are pass-through: out_data = in_data, amount ignored.
- Fill rules:
  - SLL, SRL fill with 0.
  - SRA fills with in_data[WIDTH-1].
  - ROL, ROR wrap bits around.
- Shift amount: in_amt = 0 gives out_data = in_data for every op.
- Stage k (k = 0..STAGES-1):
  - If amt[k]=1, shifts or rotates by 2^k per op; otherwise passes through.
  - Registers data, the remaining amount bits, op, and valid.
  - Bit mapping for a right shift by d: out[i] = in[i+d] for i+d < WIDTH, else fill. Left shift is symmetric.
- Latency: exactly STAGES cycles from the accept edge (in_valid & in_ready) to out_valid, when not stalled.
- Throughput: one operation per cycle.
- Stall and advance:
  - Global enable: adv = ~out_valid | out_ready.
  - All stages load only when adv=1.
  - in_ready = adv, combinational from out_ready.
  - The out_valid/out_data pair is held stable while out_valid & ~out_ready.
  - in_data/op/amt are don't-care when in_valid=0.
- Bubbles: in_valid=0 inserts a bubble (stage valid=0) that travels through the pipe. Bubbles are not collapsed.
- Simultaneous events: on a cycle where out_valid & out_ready & in_valid, the output is consumed and the new input is accepted on the same edge.
- Reset mid-operation: all in-flight results are discarded, with no partial output.
- Ordering: results leave in acceptance order; no reordering.

Optional Feature:
- Macro: BSH_CARRY_OUT_EN.
- Defined: adds output port out_carry (1 bit), registered alongside out_data.
  - SLL: carry = last bit shifted out, i.e. in_data[WIDTH-amt].
  - SRL/SRA: carry = in_data[amt-1].
  - ROL: carry = result LSB.
  - ROR: carry = result MSB.
  - amt = 0 or pass-through op: carry = 0.
  - Carry is tracked per stage.
- Undefined: port absent, no carry logic; the remaining behaviour is identical.

Decomposition:
- Package bsh_pkg:
  - op code localparams OP_SLL..OP_ROR.
  - stage-record field widths.
  - helper function for fill-bit selection.
- One sub-module, bsh_stage:
  - parameters WIDTH, DIST (= 2^k).
  - combinational shift/rotate by DIST gated by its amount bit, plus the registered payload with enable.
- Top level: generate-for over k, plus the handshake/enable logic.

Test Plan:
- WIDTH=8, SRA 0x96 amt 3 -> out_data 0xF2 after exactly 3 cycles; carry 1 if BSH_CARRY_OUT_EN.
- SLL 0x96 amt 2 -> 0x58.
- ROR 0x96 amt 3 -> 0xD2.
- ROL 0x81 amt 1 -> 0x03.
- SRL 0x80 amt 7 -> 0x01.
- Any op with amt 0 -> input unchanged.
- Op 111 on 0x5A amt 5 -> 0x5A.
- Back-to-back stream of 16 random ops with out_ready=1 -> one result per cycle, in order, all matching the reference model.
- Backpressure: hold out_ready=0 for 5 cycles with the pipe full:
  - out_data stable, in_ready=0, no loss or duplication.
  - on release, the remaining results drain in order.
- Reset mid-stream: assert rst_n=0 with 2 operations in flight -> next cycle out_valid=0; no stale result appears after reset release.
- WIDTH=32 regression: SRA 0x80000000 amt 31 -> 0xFFFFFFFF; SRL same -> 0x00000001; latency 5 cycles.

Source files
------------

// File: rtl/bsh_pkg.sv
// Shared op codes, stage-record field widths and fill helper for the pipelined barrel shifter.
package bsh_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned VALID_W = 1;

  localparam logic [OP_W-1:0] OP_SLL = 3'd0;
  localparam logic [OP_W-1:0] OP_SRL = 3'd1;
  localparam logic [OP_W-1:0] OP_SRA = 3'd2;
  localparam logic [OP_W-1:0] OP_ROL = 3'd3;
  localparam logic [OP_W-1:0] OP_ROR = 3'd4;

  // The running MSB equals the original sign bit, since earlier SRA stages fill with it.
  function automatic logic fill_bit(input logic [OP_W-1:0] op, input logic msb);
    return (op == OP_SRA) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/bsh_stage.sv
// One barrel-shifter stage: shift/rotate by DIST when its amount bit is set, then register.
// Carry tracking is built only when BSH_CARRY_OUT_EN is defined.
module bsh_stage
  import bsh_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DIST  = 1,
  localparam int unsigned SHW   = $clog2(WIDTH),
  localparam int unsigned K     = $clog2(DIST)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic [VALID_W-1:0]   i_valid,
  input  logic [WIDTH-1:0]     i_data,
  input  logic [SHW-1:0]       i_amt,
  input  logic [OP_W-1:0]      i_op,
`ifdef BSH_CARRY_OUT_EN
  input  logic                 i_carry,
  output logic                 o_carry,
`endif
  output logic [VALID_W-1:0]   o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic [SHW-1:0]       o_amt,
  output logic [OP_W-1:0]      o_op
);

  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_fill_mask;
  logic               w_fill;

  logic [VALID_W-1:0] r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [SHW-1:0]     r_amt;
  logic [OP_W-1:0]    r_op;

  assign w_fill      = fill_bit(i_op, i_data[WIDTH-1]);
  assign w_fill_mask = ~({WIDTH{1'b1}} >> DIST);

  always_comb begin
    w_res = i_data;
    if (i_amt[K]) begin
      case (i_op)
        OP_SLL:         w_res = i_data << DIST;
        OP_SRL, OP_SRA: w_res = (i_data >> DIST) | (w_fill ? w_fill_mask : '0);
        OP_ROL:         w_res = (i_data << DIST) | (i_data >> (WIDTH - DIST));
        OP_ROR:         w_res = (i_data >> DIST) | (i_data << (WIDTH - DIST));
        default:        w_res = i_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_amt   <= '0;
      r_op    <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= w_res;
      r_amt   <= i_amt;
      r_op    <= i_op;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_amt   = r_amt;
  assign o_op    = r_op;

`ifdef BSH_CARRY_OUT_EN
  logic w_carry;
  logic r_carry;

  // The last active stage owns the carry; inactive stages forward it untouched.
  always_comb begin
    w_carry = i_carry;
    if (i_amt[K]) begin
      case (i_op)
        OP_SLL:         w_carry = i_data[WIDTH-DIST];
        OP_SRL, OP_SRA: w_carry = i_data[DIST-1];
        OP_ROL:         w_carry = w_res[0];
        OP_ROR:         w_carry = w_res[WIDTH-1];
        default:        w_carry = i_carry;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_carry <= w_carry;
    end
  end

  assign o_carry = r_carry;
`endif

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter, one stage per amount bit, valid/ready on both sides.
// Optional out_carry port is enabled by defining BSH_CARRY_OUT_EN.
module pipelined_barrel_shifter
  import bsh_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  localparam int unsigned SHW    = $clog2(WIDTH),
  localparam int unsigned STAGES = SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BSH_CARRY_OUT_EN
  output logic             out_carry,
`endif
  output logic [WIDTH-1:0] out_data
);

  logic                             w_adv;
  logic [STAGES:0]                  w_valid;
  logic [STAGES:0][WIDTH-1:0]       w_data;
  logic [STAGES:0][SHW-1:0]         w_amt;
  logic [STAGES:0][OP_W-1:0]        w_op;
  logic                             w_unused_tail;

  // Whole pipe advances together; a held output freezes every stage.
  assign w_adv    = ~w_valid[STAGES] | out_ready;
  assign in_ready = w_adv;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_amt[0]   = in_amt;
  assign w_op[0]    = in_op;

`ifdef BSH_CARRY_OUT_EN
  logic [STAGES:0] w_carry;
  assign w_carry[0] = 1'b0;
  assign out_carry  = w_carry[STAGES];
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    bsh_stage #(
      .WIDTH (WIDTH),
      .DIST  (2 ** k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_amt   (w_amt[k]),
      .i_op    (w_op[k]),
`ifdef BSH_CARRY_OUT_EN
      .i_carry (w_carry[k]),
      .o_carry (w_carry[k+1]),
`endif
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_amt   (w_amt[k+1]),
      .o_op    (w_op[k+1])
    );
  end

  assign out_valid     = w_valid[STAGES];
  assign out_data      = w_data[STAGES];
  assign w_unused_tail = ^{w_amt[STAGES], w_op[STAGES]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=8 and WIDTH=32 instances).
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data, out_data;
  logic [2:0]  in_amt, in_op;

  logic        v32_in_valid, v32_in_ready, v32_out_valid;
  logic        v32_out_ready;
  logic [31:0] v32_in_data, v32_out_data;
  logic [4:0]  v32_in_amt;
  logic [2:0]  v32_in_op;

`ifdef BSH_CARRY_OUT_EN
  logic        out_carry, v32_out_carry;
`endif

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef BSH_CARRY_OUT_EN
    .out_carry (out_carry),
`endif
    .out_data  (out_data)
  );

  pipelined_barrel_shifter #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v32_in_valid),
    .in_ready  (v32_in_ready),
    .in_data   (v32_in_data),
    .in_amt    (v32_in_amt),
    .in_op     (v32_in_op),
    .out_valid (v32_out_valid),
    .out_ready (v32_out_ready),
`ifdef BSH_CARRY_OUT_EN
    .out_carry (v32_out_carry),
`endif
    .out_data  (v32_out_data)
  );

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [2:0] amt;
    logic [7:0] exp;
    logic       cy;
  } vec_t;

  vec_t       vecs [17];
  int         checks = 0;
  int         errors = 0;
  int         pushed = 0;
  int         popped = 0;
  logic [8:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bitwise reference: returns {carry, data}.
  function automatic logic [8:0] model8(input logic [2:0] op, input logic [7:0] d,
                                        input logic [2:0] a);
    logic [7:0] r;
    logic       c;
    int         s;
    s = int'(a);
    r = d;
    c = 1'b0;
    if (op <= 3'd4 && s != 0) begin
      for (int i = 0; i < 8; i++) begin
        case (op)
          3'd0:    r[i] = (i - s >= 0) ? d[i-s] : 1'b0;
          3'd1:    r[i] = (i + s < 8) ? d[i+s] : 1'b0;
          3'd2:    r[i] = (i + s < 8) ? d[i+s] : d[7];
          3'd3:    r[i] = d[(i - s + 8) % 8];
          default: r[i] = d[(i + s) % 8];
        endcase
      end
      case (op)
        3'd0:       c = d[8-s];
        3'd1, 3'd2: c = d[s-1];
        3'd3:       c = r[0];
        default:    c = r[7];
      endcase
    end
    return {c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    in_valid = 1'b1;
    in_op    = 3'($urandom_range(0, 7));
    in_data  = 8'($urandom);
    in_amt   = 3'($urandom);
  endtask

  // Scoreboard bookkeeping on the pre-edge view, then advance one clock.
  task automatic step();
    logic [8:0] e;
    #1;
    if (in_valid && in_ready) begin
      sb.push_back(model8(in_op, in_data, in_amt));
      pushed++;
    end
    if (out_valid && out_ready) begin
      popped++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got 0x%0h with empty scoreboard", out_data);
      end else begin
        e = sb.pop_front();
        check("stream_data", out_data, e[7:0]);
`ifdef BSH_CARRY_OUT_EN
        check("stream_carry", out_carry, e[8]);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    int lat;
    in_valid = 1'b1;
    in_op    = vecs[i].op;
    in_data  = vecs[i].data;
    in_amt   = vecs[i].amt;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
`ifdef BSH_CARRY_OUT_EN
    check($sformatf("vec%0d_carry", i), out_carry, vecs[i].cy);
`endif
    tick();
  endtask

  task automatic run32(input string name, input logic [2:0] op, input logic [31:0] d,
                       input logic [4:0] a, input logic [31:0] exp, input logic cy);
    int lat;
    v32_in_valid = 1'b1;
    v32_in_op    = op;
    v32_in_data  = d;
    v32_in_amt   = a;
    tick();
    v32_in_valid = 1'b0;
    lat = 1;
    while (!v32_out_valid && lat < 12) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd5);
    check({name, "_data"}, v32_out_data, exp);
`ifdef BSH_CARRY_OUT_EN
    check({name, "_carry"}, v32_out_carry, cy);
`else
    if (cy === 1'bx) $display("note: carry argument undefined for %s", name);
`endif
    tick();
  endtask

  initial begin
    logic [7:0] held;
    bit         seen;

    vecs[0]  = '{3'd2, 8'h96, 3'd3, 8'hF2, 1'b1};
    vecs[1]  = '{3'd0, 8'h96, 3'd2, 8'h58, 1'b0};
    vecs[2]  = '{3'd4, 8'h96, 3'd3, 8'hD2, 1'b1};
    vecs[3]  = '{3'd3, 8'h81, 3'd1, 8'h03, 1'b1};
    vecs[4]  = '{3'd1, 8'h80, 3'd7, 8'h01, 1'b0};
    vecs[5]  = '{3'd0, 8'hA5, 3'd0, 8'hA5, 1'b0};
    vecs[6]  = '{3'd1, 8'hA5, 3'd0, 8'hA5, 1'b0};
    vecs[7]  = '{3'd2, 8'hA5, 3'd0, 8'hA5, 1'b0};
    vecs[8]  = '{3'd3, 8'hA5, 3'd0, 8'hA5, 1'b0};
    vecs[9]  = '{3'd4, 8'hA5, 3'd0, 8'hA5, 1'b0};
    vecs[10] = '{3'd7, 8'h5A, 3'd5, 8'h5A, 1'b0};
    vecs[11] = '{3'd5, 8'h3C, 3'd3, 8'h3C, 1'b0};
    vecs[12] = '{3'd6, 8'hC3, 3'd1, 8'hC3, 1'b0};
    vecs[13] = '{3'd2, 8'h7F, 3'd4, 8'h07, 1'b1};
    vecs[14] = '{3'd0, 8'hFF, 3'd7, 8'h80, 1'b1};
    vecs[15] = '{3'd3, 8'h96, 3'd4, 8'h69, 1'b1};
    vecs[16] = '{3'd1, 8'h96, 3'd1, 8'h4B, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
    v32_in_valid = 1'b0; v32_in_data = '0; v32_in_amt = '0; v32_in_op = '0;
    v32_out_ready = 1'b1;
    tick();
    tick();
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_out_valid32", v32_out_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_reset_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 17; i++) run_vec(i);

    // Back-to-back stream: each result must drain exactly STAGES cycles after the last accept.
    out_ready = 1'b1;
    pushed = 0;
    popped = 0;
    for (int i = 0; i < 16; i++) begin
      drive_rand();
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("stream_count", 32'(popped), 32'd16);
    check("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: fill the pipe with out_ready low, stall five cycles, then drain.
    pushed = 0;
    popped = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      step();
    end
    drive_rand();
    held = sb[0][7:0];
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_data", out_data, held);
      step();
    end
    check("stall_pushed", 32'(pushed), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      drive_rand();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("bp_pushed", 32'(pushed), 32'd5);
    check("bp_popped", 32'(popped), 32'd5);

    // Reset with two operations in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_rand();
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_out_data", out_data, 8'h00);
    sb.delete();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midreset_no_stale", seen, 1'b0);
    check("midreset_in_ready", in_ready, 1'b1);

    run32("w32_sra", 3'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
    run32("w32_srl", 3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0);
    run32("w32_rol", 3'd3, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
